// File: rtl/buyruk_onbellek_denetleyici_kume_pkg.sv
// Shared definitions for the set-associative instruction cache controller:
// FSM state encoding and address-split width helpers.
package buyruk_onbellek_denetleyici_kume_pkg;

   typedef enum logic [2:0] {
      BOSTA         = 3'd0,
      ONBELLEK_OKU  = 3'd1,
      ANABELLEK_OKU = 3'd2,
      ONBELLEK_YAZ  = 3'd3,
      TEMIZLE       = 3'd4
   } durum_e;

   // Byte offset inside a line: word select bits plus the two byte bits.
   function automatic int unsigned ofset_bit(input int unsigned blok_kelime);
      return $clog2(blok_kelime) + 2;
   endfunction

   function automatic int unsigned satir_secim_bit(input int unsigned satir_sayisi);
      return $clog2(satir_sayisi);
   endfunction

   function automatic int unsigned etiket_bit(input int unsigned adres_bit,
                                              input int unsigned satir_sayisi,
                                              input int unsigned blok_kelime);
      return adres_bit - ofset_bit(blok_kelime) - satir_secim_bit(satir_sayisi);
   endfunction

   function automatic int unsigned blok_bit(input int unsigned veri_bit,
                                            input int unsigned blok_kelime);
      return veri_bit * blok_kelime;
   endfunction

   // A direct-mapped build still needs a 1-bit way index to keep widths legal.
   function automatic int unsigned yol_bit(input int unsigned yol_sayisi);
      return (yol_sayisi > 1) ? $clog2(yol_sayisi) : 1;
   endfunction

endpackage

// File: rtl/buyruk_onbellek_yol_dizisi.sv
// One cache way: tag and data arrays with a registered (1-cycle) synchronous read
// and a synchronous write port.
module buyruk_onbellek_yol_dizisi #(
   parameter int unsigned SATIR_SAYISI    = 256,
   parameter int unsigned SATIR_SECIM_BIT = 8,
   parameter int unsigned ETIKET_BIT      = 20,
   parameter int unsigned BLOK_BIT        = 128
) (
   input  logic                       clk_i,
   input  logic                       oku_i,
   input  logic [SATIR_SECIM_BIT-1:0] oku_satir_i,
   input  logic                       yaz_i,
   input  logic [SATIR_SECIM_BIT-1:0] yaz_satir_i,
   input  logic [ETIKET_BIT-1:0]      yaz_etiket_i,
   input  logic [BLOK_BIT-1:0]        yaz_blok_i,
   output logic [ETIKET_BIT-1:0]      etiket_o,
   output logic [BLOK_BIT-1:0]        blok_o
);

   logic [ETIKET_BIT-1:0] etiket_mem [SATIR_SAYISI];
   logic [BLOK_BIT-1:0]   blok_mem   [SATIR_SAYISI];

   always_ff @(posedge clk_i) begin
      if (yaz_i) begin
         etiket_mem[yaz_satir_i] <= yaz_etiket_i;
         blok_mem[yaz_satir_i]   <= yaz_blok_i;
      end
      if (oku_i) begin
         etiket_o <= etiket_mem[oku_satir_i];
         blok_o   <= blok_mem[oku_satir_i];
      end
   end

endmodule

// File: rtl/buyruk_onbellek_denetleyici_kume.sv
// N-way set-associative instruction cache controller between fetch and main memory:
// round-robin replacement, one-per-cycle hits, refill bypass and deferred flush.
module buyruk_onbellek_denetleyici_kume
   import buyruk_onbellek_denetleyici_kume_pkg::*;
#(
   parameter int unsigned ADRES_BIT    = 32,
   parameter int unsigned VERI_BIT     = 32,
   parameter int unsigned SATIR_SAYISI = 256,
   parameter int unsigned YOL_SAYISI   = 2,
   parameter int unsigned BLOK_KELIME  = 4
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            getir_okuma_istek_gecerli_i,
   input  logic [ADRES_BIT-1:0]            getir_okuma_istek_adres_i,
   output logic                            getir_okuma_istek_kabul_o,
   output logic [VERI_BIT-1:0]             getir_okuma_istek_buyruk_o,
   output logic                            getir_okuma_istek_hazir_o,
   input  logic                            onbellek_temizle_i,
   output logic                            onbellek_mesgul_o,
   output logic [ADRES_BIT-1:0]            anabellek_denetleyici_okuma_istek_adres_o,
   output logic                            anabellek_denetleyici_okuma_istek_gecerli_o,
   input  logic [VERI_BIT*BLOK_KELIME-1:0] anabellek_denetleyici_okuma_veri_blok_i,
   input  logic                            anabellek_denetleyici_okuma_istek_hazir_i
);

   localparam int unsigned OFSET_BIT       = ofset_bit(BLOK_KELIME);
   localparam int unsigned KELIME_BIT      = OFSET_BIT - 2;
   localparam int unsigned SATIR_SECIM_BIT = satir_secim_bit(SATIR_SAYISI);
   localparam int unsigned ETIKET_BIT      = etiket_bit(ADRES_BIT, SATIR_SAYISI, BLOK_KELIME);
   localparam int unsigned BLOK_BIT        = blok_bit(VERI_BIT, BLOK_KELIME);
   localparam int unsigned YOL_BIT         = yol_bit(YOL_SAYISI);

   durum_e                durum_q, durum_d;
   logic [ADRES_BIT-1:0]  adres_q, adres_d;
   logic [BLOK_BIT-1:0]   blok_q, blok_d;
   logic                  bekle_q, bekle_d;
   logic                  hazir_q, hazir_d;
   logic [VERI_BIT-1:0]   buyruk_q, buyruk_d;
   logic                  mesgul_q;
   logic                  mem_gecerli_q;
   logic [ADRES_BIT-1:0]  mem_adres_q;
   logic [YOL_SAYISI-1:0] gecerli_q [SATIR_SAYISI];
   logic [YOL_SAYISI-1:0] gecerli_d [SATIR_SAYISI];
   logic [YOL_BIT-1:0]    rr_q [SATIR_SAYISI];
   logic [YOL_BIT-1:0]    rr_d [SATIR_SAYISI];

   logic [SATIR_SECIM_BIT-1:0] satir_c, gelen_satir_c;
   logic [ETIKET_BIT-1:0]      etiket_c;
   logic [KELIME_BIT-1:0]      kelime_c;
   logic [ETIKET_BIT-1:0]      yol_etiket_c [YOL_SAYISI];
   logic [BLOK_BIT-1:0]        yol_blok_c   [YOL_SAYISI];
   logic [YOL_SAYISI-1:0]      yol_yaz_c;
   logic                       oku_c, kabul_c, isabet_c, isabet_hazir_c, kurban_dolu_c;
   logic [BLOK_BIT-1:0]        isabet_blok_c;
   logic [VERI_BIT-1:0]        isabet_kelime_c, dolum_kelime_c;
   logic [YOL_BIT-1:0]         kurban_c;
   logic                       unused_c;

   assign satir_c       = adres_q[OFSET_BIT +: SATIR_SECIM_BIT];
   assign gelen_satir_c = getir_okuma_istek_adres_i[OFSET_BIT +: SATIR_SECIM_BIT];
   assign etiket_c      = adres_q[ADRES_BIT-1 -: ETIKET_BIT];
   assign kelime_c      = adres_q[2 +: KELIME_BIT];
   assign unused_c      = ^adres_q[1:0];

   for (genvar w = 0; w < YOL_SAYISI; w++) begin : g_yol
      buyruk_onbellek_yol_dizisi #(
         .SATIR_SAYISI    (SATIR_SAYISI),
         .SATIR_SECIM_BIT (SATIR_SECIM_BIT),
         .ETIKET_BIT      (ETIKET_BIT),
         .BLOK_BIT        (BLOK_BIT)
      ) u_yol (
         .clk_i        (clk_i),
         .oku_i        (oku_c),
         .oku_satir_i  (gelen_satir_c),
         .yaz_i        (yol_yaz_c[w]),
         .yaz_satir_i  (satir_c),
         .yaz_etiket_i (etiket_c),
         .yaz_blok_i   (blok_q),
         .etiket_o     (yol_etiket_c[w]),
         .blok_o       (yol_blok_c[w])
      );
   end

   // Tag compare across the ways; tags are unique per set so at most one matches.
   always_comb begin
      isabet_c      = 1'b0;
      isabet_blok_c = '0;
      for (int w = 0; w < int'(YOL_SAYISI); w++) begin
         if (gecerli_q[satir_c][w] && (yol_etiket_c[w] == etiket_c)) begin
            isabet_c      = 1'b1;
            isabet_blok_c = yol_blok_c[w];
         end
      end
   end

   always_comb begin
      isabet_kelime_c = '0;
      dolum_kelime_c  = '0;
      for (int k = 0; k < int'(BLOK_KELIME); k++) begin
         if (kelime_c == KELIME_BIT'(k)) begin
            isabet_kelime_c = isabet_blok_c[k*VERI_BIT +: VERI_BIT];
            dolum_kelime_c  = blok_q[k*VERI_BIT +: VERI_BIT];
         end
      end
   end

   // Lowest invalid way wins; only a full set falls back to the round-robin pointer.
   always_comb begin
      kurban_c      = rr_q[satir_c];
      kurban_dolu_c = 1'b1;
      for (int w = int'(YOL_SAYISI) - 1; w >= 0; w--) begin
         if (!gecerli_q[satir_c][w]) begin
            kurban_c      = YOL_BIT'(w);
            kurban_dolu_c = 1'b0;
         end
      end
   end

   always_comb begin
      yol_yaz_c = '0;
      if (durum_q == ONBELLEK_YAZ) yol_yaz_c[kurban_c] = 1'b1;
   end

   always_comb begin
      durum_d        = durum_q;
      adres_d        = adres_q;
      blok_d         = blok_q;
      bekle_d        = bekle_q;
      hazir_d        = 1'b0;
      buyruk_d       = '0;
      gecerli_d      = gecerli_q;
      rr_d           = rr_q;
      kabul_c        = 1'b0;
      oku_c          = 1'b0;
      isabet_hazir_c = 1'b0;
      case (durum_q)
         BOSTA: begin
            bekle_d = 1'b0;
            if (onbellek_temizle_i || bekle_q) begin
               durum_d = TEMIZLE;
            end else if (getir_okuma_istek_gecerli_i) begin
               kabul_c = 1'b1;
               oku_c   = 1'b1;
               adres_d = getir_okuma_istek_adres_i;
               durum_d = ONBELLEK_OKU;
            end
         end
         ONBELLEK_OKU: begin
            bekle_d = bekle_q | onbellek_temizle_i;
            if (isabet_c) begin
               isabet_hazir_c = 1'b1;
               if (getir_okuma_istek_gecerli_i && !onbellek_temizle_i && !bekle_q) begin
                  kabul_c = 1'b1;
                  oku_c   = 1'b1;
                  adres_d = getir_okuma_istek_adres_i;
               end else begin
                  durum_d = BOSTA;
               end
            end else begin
               durum_d = ANABELLEK_OKU;
            end
         end
         ANABELLEK_OKU: begin
            bekle_d = bekle_q | onbellek_temizle_i;
            if (anabellek_denetleyici_okuma_istek_hazir_i) begin
               blok_d  = anabellek_denetleyici_okuma_veri_blok_i;
               durum_d = ONBELLEK_YAZ;
            end
         end
         ONBELLEK_YAZ: begin
            bekle_d = bekle_q | onbellek_temizle_i;
            gecerli_d[satir_c][kurban_c] = 1'b1;
            if (kurban_dolu_c) begin
               rr_d[satir_c] = (rr_q[satir_c] == YOL_BIT'(YOL_SAYISI - 1)) ?
                               '0 : rr_q[satir_c] + YOL_BIT'(1);
            end
            hazir_d  = 1'b1;
            buyruk_d = dolum_kelime_c;
            durum_d  = BOSTA;
         end
         TEMIZLE: begin
            bekle_d = 1'b0;
            for (int s = 0; s < int'(SATIR_SAYISI); s++) begin
               gecerli_d[s] = '0;
               rr_d[s]      = '0;
            end
            durum_d = BOSTA;
         end
         default: durum_d = BOSTA;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         durum_q       <= BOSTA;
         adres_q       <= '0;
         blok_q        <= '0;
         bekle_q       <= 1'b0;
         hazir_q       <= 1'b0;
         buyruk_q      <= '0;
         mesgul_q      <= 1'b0;
         mem_gecerli_q <= 1'b0;
         mem_adres_q   <= '0;
         for (int s = 0; s < int'(SATIR_SAYISI); s++) begin
            gecerli_q[s] <= '0;
            rr_q[s]      <= '0;
         end
      end else begin
         durum_q       <= durum_d;
         adres_q       <= adres_d;
         blok_q        <= blok_d;
         bekle_q       <= bekle_d;
         hazir_q       <= hazir_d;
         buyruk_q      <= buyruk_d;
         mesgul_q      <= !(durum_d inside {BOSTA, ONBELLEK_OKU});
         mem_gecerli_q <= (durum_d == ANABELLEK_OKU);
         mem_adres_q   <= (durum_d == ANABELLEK_OKU) ?
                          {adres_d[ADRES_BIT-1:OFSET_BIT], {OFSET_BIT{1'b0}}} : '0;
         gecerli_q     <= gecerli_d;
         rr_q          <= rr_d;
      end
   end

   // Hits answer combinationally from the RAM outputs; refills answer from the response register.
   assign getir_okuma_istek_kabul_o  = kabul_c;
   assign getir_okuma_istek_hazir_o  = isabet_hazir_c | hazir_q;
   assign getir_okuma_istek_buyruk_o = isabet_hazir_c ? isabet_kelime_c : buyruk_q;
   assign onbellek_mesgul_o          = mesgul_q;
   assign anabellek_denetleyici_okuma_istek_gecerli_o = mem_gecerli_q;
   assign anabellek_denetleyici_okuma_istek_adres_o   = mem_adres_q;

endmodule

// File: tb/tb_buyruk_onbellek_denetleyici_kume.sv
// Directed bench for the set-associative instruction cache controller
// (2 ways, 256 sets, 4-word lines).
module tb_buyruk_onbellek_denetleyici_kume;

   localparam logic [31:0] DESEN = 32'hC3C3_0000;

   logic         clk;
   logic         rst_n;
   logic         gecerli;
   logic [31:0]  adres;
   logic         kabul;
   logic [31:0]  buyruk;
   logic         hazir;
   logic         temizle;
   logic         mesgul;
   logic [31:0]  mem_adres;
   logic         mem_gecerli;
   logic [127:0] mem_blok;
   logic         mem_hazir;

   int checks = 0;
   int errors = 0;

   buyruk_onbellek_denetleyici_kume #(
      .ADRES_BIT    (32),
      .VERI_BIT     (32),
      .SATIR_SAYISI (256),
      .YOL_SAYISI   (2),
      .BLOK_KELIME  (4)
   ) dut (
      .clk_i                                       (clk),
      .rst_ni                                      (rst_n),
      .getir_okuma_istek_gecerli_i                 (gecerli),
      .getir_okuma_istek_adres_i                   (adres),
      .getir_okuma_istek_kabul_o                   (kabul),
      .getir_okuma_istek_buyruk_o                  (buyruk),
      .getir_okuma_istek_hazir_o                   (hazir),
      .onbellek_temizle_i                          (temizle),
      .onbellek_mesgul_o                           (mesgul),
      .anabellek_denetleyici_okuma_istek_adres_o   (mem_adres),
      .anabellek_denetleyici_okuma_istek_gecerli_o (mem_gecerli),
      .anabellek_denetleyici_okuma_veri_blok_i     (mem_blok),
      .anabellek_denetleyici_okuma_istek_hazir_i   (mem_hazir)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [127:0] mkblk(input logic [31:0] taban);
      logic [127:0] b;
      for (int k = 0; k < 4; k++) b[k*32 +: 32] = (taban | 32'(k*4)) ^ DESEN;
      return b;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Fetch that must hit: response one cycle after acceptance, no memory traffic.
   task automatic fetch_hit(input string tag, input logic [31:0] a);
      gecerli = 1'b1;
      adres   = a;
      #1;
      chk({tag, "_kabul"}, 128'(kabul), 128'(1'b1));
      tick();
      gecerli = 1'b0;
      #1;
      chk({tag, "_hazir"}, 128'(hazir), 128'(1'b1));
      chk({tag, "_buyruk"}, 128'(buyruk), 128'(a ^ DESEN));
      chk({tag, "_mem_yok"}, 128'(mem_gecerli), 128'(1'b0));
      tick();
      chk({tag, "_hazir_bitti"}, 128'(hazir), 128'(1'b0));
   endtask

   // Fetch that must miss: memory request, refill after lat cycles, response 2 cycles after hazir_i.
   task automatic fetch_miss(input string tag, input logic [31:0] a, input int lat, input bit flush);
      gecerli = 1'b1;
      adres   = a;
      #1;
      chk({tag, "_kabul"}, 128'(kabul), 128'(1'b1));
      tick();
      gecerli = 1'b0;
      #1;
      chk({tag, "_oku_hazir_yok"}, 128'(hazir), 128'(1'b0));
      tick();
      chk({tag, "_mem_gecerli"}, 128'(mem_gecerli), 128'(1'b1));
      chk({tag, "_mem_adres"}, 128'(mem_adres), 128'(a & 32'hFFFF_FFF0));
      chk({tag, "_mesgul"}, 128'(mesgul), 128'(1'b1));
      if (flush) temizle = 1'b1;
      for (int i = 0; i < lat; i++) begin
         tick();
         temizle = 1'b0;
         chk({tag, "_mem_tutulu"}, 128'(mem_gecerli), 128'(1'b1));
         chk({tag, "_mem_adres_sabit"}, 128'(mem_adres), 128'(a & 32'hFFFF_FFF0));
      end
      mem_blok  = mkblk(a & 32'hFFFF_FFF0);
      mem_hazir = 1'b1;
      tick();
      mem_hazir = 1'b0;
      temizle   = 1'b0;
      #1;
      chk({tag, "_yaz_hazir_yok"}, 128'(hazir), 128'(1'b0));
      chk({tag, "_yaz_mem_dustu"}, 128'(mem_gecerli), 128'(1'b0));
      tick();
      chk({tag, "_hazir"}, 128'(hazir), 128'(1'b1));
      chk({tag, "_buyruk"}, 128'(buyruk), 128'(a ^ DESEN));
      tick();
      chk({tag, "_hazir_bitti"}, 128'(hazir), 128'(1'b0));
   endtask

   initial begin
      rst_n     = 1'b0;
      gecerli   = 1'b0;
      adres     = '0;
      temizle   = 1'b0;
      mem_blok  = '0;
      mem_hazir = 1'b0;
      tick();
      tick();
      chk("reset_hazir", 128'(hazir), 128'(1'b0));
      chk("reset_buyruk", 128'(buyruk), 128'(0));
      chk("reset_mem_gecerli", 128'(mem_gecerli), 128'(1'b0));
      chk("reset_mem_adres", 128'(mem_adres), 128'(0));
      chk("reset_mesgul", 128'(mesgul), 128'(1'b0));
      rst_n = 1'b1;
      tick();
      chk("bosta_kabul", 128'(kabul), 128'(1'b0));

      // 1: cold miss then hit
      fetch_miss("t1_miss", 32'h0000_1004, 2, 1'b0);
      fetch_hit("t1_hit", 32'h0000_1004);

      // 2: four back-to-back hits on one line
      gecerli = 1'b1;
      adres   = 32'h0000_1000;
      #1;
      chk("t2_kabul0", 128'(kabul), 128'(1'b1));
      for (int i = 1; i < 4; i++) begin
         tick();
         adres = 32'h0000_1000 + 32'(i*4);
         #1;
         chk("t2_hazir", 128'(hazir), 128'(1'b1));
         chk("t2_buyruk", 128'(buyruk), 128'((32'h0000_1000 + 32'(i*4 - 4)) ^ DESEN));
         chk("t2_kabul", 128'(kabul), 128'(1'b1));
         chk("t2_mem_yok", 128'(mem_gecerli), 128'(1'b0));
      end
      tick();
      gecerli = 1'b0;
      #1;
      chk("t2_hazir_son", 128'(hazir), 128'(1'b1));
      chk("t2_buyruk_son", 128'(buyruk), 128'(32'h0000_100C ^ DESEN));
      chk("t2_kabul_son", 128'(kabul), 128'(1'b0));
      tick();
      chk("t2_bitti", 128'(hazir), 128'(1'b0));
      chk("t2_mem_yok_son", 128'(mem_gecerli), 128'(1'b0));

      // 4: idle flush, one TEMIZLE cycle, request blocked during it
      temizle = 1'b1;
      #1;
      chk("t4_kabul_yok", 128'(kabul), 128'(1'b0));
      tick();
      temizle = 1'b0;
      gecerli = 1'b1;
      adres   = 32'h0000_1004;
      #1;
      chk("t4_mesgul", 128'(mesgul), 128'(1'b1));
      chk("t4_temizle_kabul_yok", 128'(kabul), 128'(1'b0));
      tick();
      chk("t4_mesgul_bitti", 128'(mesgul), 128'(1'b0));
      fetch_miss("t4_miss", 32'h0000_1004, 1, 1'b0);

      // 5: flush during refill: response still delivered, then flush runs
      fetch_miss("t5_miss", 32'h0000_3008, 2, 1'b1);
      chk("t5_temizle_mesgul", 128'(mesgul), 128'(1'b1));
      tick();
      chk("t5_mesgul_bitti", 128'(mesgul), 128'(1'b0));
      fetch_miss("t5_tekrar_miss", 32'h0000_3008, 1, 1'b0);

      // 3: replacement in one set, after clearing the cache
      temizle = 1'b1;
      tick();
      temizle = 1'b0;
      tick();
      fetch_miss("t3_a", 32'h0000_2000, 1, 1'b0);
      fetch_miss("t3_b", 32'h0001_2000, 1, 1'b0);
      fetch_miss("t3_c", 32'h0002_2000, 1, 1'b0);
      fetch_hit("t3_b_hit", 32'h0001_2004);
      fetch_miss("t3_a_miss", 32'h0000_2008, 1, 1'b0);
      fetch_hit("t3_c_hit", 32'h0002_200C);
      fetch_miss("t3_b_miss", 32'h0001_2000, 0, 1'b0);

      // 6: reset in the middle of a refill, late hazir_i ignored
      gecerli = 1'b1;
      adres   = 32'h0000_4004;
      tick();
      gecerli = 1'b0;
      tick();
      chk("t6_mem_gecerli", 128'(mem_gecerli), 128'(1'b1));
      rst_n = 1'b0;
      #1;
      chk("t6_rst_mem_gecerli", 128'(mem_gecerli), 128'(1'b0));
      chk("t6_rst_mem_adres", 128'(mem_adres), 128'(0));
      chk("t6_rst_mesgul", 128'(mesgul), 128'(1'b0));
      chk("t6_rst_hazir", 128'(hazir), 128'(1'b0));
      tick();
      rst_n     = 1'b1;
      mem_blok  = mkblk(32'h0000_4000);
      mem_hazir = 1'b1;
      #1;
      chk("t6_gec_hazir_kabul", 128'(kabul), 128'(1'b0));
      tick();
      mem_hazir = 1'b0;
      #1;
      chk("t6_hazir_yok", 128'(hazir), 128'(1'b0));
      chk("t6_mesgul_yok", 128'(mesgul), 128'(1'b0));
      chk("t6_mem_yok", 128'(mem_gecerli), 128'(1'b0));
      tick();
      chk("t6_hazir_yok2", 128'(hazir), 128'(1'b0));
      chk("t6_buyruk_sifir", 128'(buyruk), 128'(0));
      fetch_miss("t6_miss", 32'h0000_4004, 1, 1'b0);
      fetch_miss("t6_eski_miss", 32'h0002_200C, 1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/buyruk_onbellek_denetleyici_kume.md
Name: buyruk_onbellek_denetleyici_kume

Overview:
Parametrised N-way set-associative instruction cache controller, with tag, valid and data arrays held internally. It sits between the fetch stage and the main memory controller and replaces the direct-mapped controller. It adds:
- configurable ways, sets and line size;
- per-line valid bits cleared by reset;
- round-robin replacement;
- back-to-back hit throughput of one per cycle;
- critical-word bypass on refill;
- a flush (fence.i) input.

Parameters:
ADRES_BIT, 32, fetch address width
VERI_BIT, 32, instruction word width
SATIR_SAYISI, 256, number of sets (power of 2, >=2)
YOL_SAYISI, 2, ways per set (1, 2 or 4)
BLOK_KELIME, 4, words per line (power of 2, >=2); memory block width = VERI_BIT*BLOK_KELIME

Ports:
clk_i  in  1  clock
rst_ni  in  1  one clock; reset is asynchronous and active-low
getir_okuma_istek_gecerli_i  in  1  fetch request valid; held until accepted
getir_okuma_istek_adres_i  in  ADRES_BIT  fetch byte address (word aligned)
getir_okuma_istek_kabul_o  out  1  request accepted this cycle
getir_okuma_istek_buyruk_o  out  VERI_BIT  returned instruction
getir_okuma_istek_hazir_o  out  1  one-cycle pulse, buyruk valid
onbellek_temizle_i  in  1  flush pulse: invalidate all lines
onbellek_mesgul_o  out  1  high in any state other than BOSTA/ONBELLEK_OKU
anabellek_denetleyici_okuma_istek_adres_o  out  ADRES_BIT  line-aligned miss address
anabellek_denetleyici_okuma_istek_gecerli_o  out  1  miss request; held until hazir
anabellek_denetleyici_okuma_veri_blok_i  in  VERI_BIT*BLOK_KELIME  refill line, word 0 in LSBs
anabellek_denetleyici_okuma_istek_hazir_i  in  1  refill data valid (one-cycle pulse)

Behaviour:
- Address split:
  - offset = log2(BLOK_KELIME)+2 LSBs;
  - word select = offset[MSB:2];
  - index = next log2(SATIR_SAYISI) bits;
  - tag = remaining MSBs.
- Arrays: tag/data use synchronous-read RAM with 1-cycle latency. Valid bits and per-set round-robin pointers are flops.
- Reset (async assert, sync release): state BOSTA; all valid bits 0; pointers 0; all outputs 0; address register 0.
- States: BOSTA, ONBELLEK_OKU, ANABELLEK_OKU, ONBELLEK_YAZ, TEMIZLE.
- BOSTA:
  - If temizle (or a latched pending flush): go to TEMIZLE, kabul=0. Flush has priority.
  - Else if gecerli: kabul=1, latch the address, read all ways at the index, go to ONBELLEK_OKU.
- ONBELLEK_OKU: hit = any way with valid && tag equal. Way tags are unique per set by construction.
  - Hit:
    - drive hazir=1 and the selected word;
    - if a new gecerli is present and no flush is pending: accept it the same cycle (kabul=1), stay in ONBELLEK_OKU;
    - else return to BOSTA.
    - Hit latency is 1 cycle after acceptance.
  - Miss: go to ANABELLEK_OKU, kabul=0.
- ANABELLEK_OKU:
  - gecerli_o=1 with a line-aligned address, stable until hazir_i.
  - On hazir_i, capture the block and go to ONBELLEK_YAZ.
- ONBELLEK_YAZ:
  - Victim = first invalid way (lowest index), else the set's round-robin pointer.
  - Write tag+data, set valid; the pointer advances (mod YOL_SAYISI) only when a valid line is evicted.
  - Drive hazir=1 with the requested word from the captured block (bypass, no re-read).
  - Go to BOSTA.
  - Miss latency = memory latency + 2 cycles.
- TEMIZLE: clear all valid bits and pointers in one cycle, go to BOSTA.
- Flush during ONBELLEK_OKU/ANABELLEK_OKU/ONBELLEK_YAZ:
  - latched as pending and executed on the next BOSTA entry;
  - an in-flight refill still completes and still responds, then is invalidated by the flush.
- Flush in ONBELLEK_OKU with a hit: the response is delivered, but no new request is accepted that cycle.
- YOL_SAYISI=1 degenerates to direct-mapped; pointer logic is unused.
- Reset mid-refill:
  - all state is dropped; a late hazir_i after reset is ignored in BOSTA;
  - the memory controller is reset by the same rst_ni.
- hazir_i outside ANABELLEK_OKU is ignored.

Decomposition:
- Shared package/header (memory_definitions.vh): derived widths (OFSET_BIT, SATIR_SECIM_BIT, ETIKET_BIT, BLOK_BIT) as functions of the parameters, plus state encodings.
- One sub-module, buyruk_onbellek_yol_dizisi: per-way tag+data synchronous RAM, instantiated YOL_SAYISI times via generate.

Test Plan:
1. Reset, then fetch 0x0000_1004 → miss; memory request at 0x0000_1000; return block {W3,W2,W1,W0} → hazir with W1 exactly 2 cycles after hazir_i. Refetch 0x1004 → hit, hazir 1 cycle after kabul.
2. Preload the line at 0x1000, then issue 0x1000, 0x1004, 0x1008, 0x100C back-to-back → four consecutive hazir cycles returning W0..W3, no memory requests.
3. YOL_SAYISI=2, SATIR_SAYISI=256: fill 0x0000_2000, 0x0001_2000, 0x0002_2000 (same index) → third evicts way 0 (0x2000). Refetching 0x2000 misses; 0x0001_2000 still hits.
4. Flush pulse while idle with lines valid → TEMIZLE for one cycle. The next fetch of a previously cached address misses.
5. Flush asserted during ANABELLEK_OKU → refill completes and responds. Flush then executes, so the same address misses afterwards.
6. Assert rst_ni low mid-refill, then pulse hazir_i after release → no hazir_o, no array write; outputs 0; the next fetch misses normally.
